// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA frame grabber.
package vga_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_VSYNC   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_ccitt_24.sv
// Combinational CRC-16-CCITT update folding one 24-bit pixel, MSB first.
module crc16_ccitt_24
  import vga_capture_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [23:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c_s;

  // Bit-serial shift unrolled over the 24 pixel bits.
  always_comb begin
    c_s = crc_i;
    for (int i = 23; i >= 0; i--) begin
      if (c_s[15] ^ data_i[i]) begin
        c_s = {c_s[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c_s = {c_s[14:0], 1'b0};
      end
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one visible VGA frame into a linear frame memory on request.
// Optional frame CRC is built when VGA_CAPTURE_CRC_EN is defined.
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              n_blanc,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              line_err,
  output logic              frame_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic [15:0]       crc
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned LW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX  = XW'(H_ACTIVE);
  localparam logic [LW-1:0]     L_LAST = LW'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  state_e              state_q;
  logic                vs_prev_q;
  logic                nb_prev_q;
  logic [XW-1:0]       x_q;
  logic [LW-1:0]       line_q;
  logic [ADDR_W-1:0]   base_q;
  logic                busy_q;
  logic                done_q;
  logic                line_err_q;
  logic                frame_err_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [23:0]         wr_data_q;

  logic                vs_fall_s;
  logic                vs_rise_s;
  logic                nb_fall_s;
  logic                unused_s;

  assign unused_s  = hsync;

  assign vs_fall_s = pix_en & vs_prev_q & ~vsync;
  assign vs_rise_s = pix_en & ~vs_prev_q & vsync;
  assign nb_fall_s = pix_en & nb_prev_q & ~n_blanc;

  // Previous-sample history; vsync idles high, so reset it high to avoid a false fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev_q <= 1'b1;
      nb_prev_q <= 1'b0;
    end else if (pix_en) begin
      vs_prev_q <= vsync;
      nb_prev_q <= n_blanc;
    end
  end

  // Capture FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      line_q      <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 24'h0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_ARMED;
            busy_q      <= 1'b1;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (vs_fall_s) begin
            state_q <= ST_VSYNC;
          end
        end
        ST_VSYNC: begin
          if (vs_rise_s) begin
            state_q <= ST_CAPTURE;
            x_q     <= '0;
            line_q  <= '0;
            base_q  <= '0;
          end
        end
        ST_CAPTURE: begin
          // Line close takes precedence over a coincident vsync fall.
          if (nb_fall_s) begin
            if (x_q != X_MAX) begin
              line_err_q <= 1'b1;
            end
            base_q <= base_q + H_STEP;
            x_q    <= '0;
            line_q <= line_q + LW'(1);
            if (line_q == L_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (vs_fall_s) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else if (vs_fall_s) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
          end else if (pix_en && n_blanc) begin
            if (x_q < X_MAX) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q + ADDR_W'(x_q);
              wr_data_q <= {r, g, b};
              x_q       <= x_q + XW'(1);
            end else begin
              line_err_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign line_err  = line_err_q;
  assign frame_err = frame_err_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_d;

  crc16_ccitt_24 u_crc (
    .crc_i  (crc_q),
    .data_i (wr_data_q),
    .crc_o  (crc_d)
  );

  // Running CRC folds each pixel in its write cycle; restarts on an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 16'h0000;
    end else if (state_q == ST_IDLE && start) begin
      crc_q <= CRC_INIT;
    end else if (wr_en_q) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;
`else
  assign crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture on a reduced 16x12 frame.
module tb_vga_frame_capture;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_en, hsync, vsync, n_blanc, start;
  logic [7:0]    r, g, b;
  logic          busy, done, line_err, frame_err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [15:0]   crc;

  vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .n_blanc(n_blanc), .r(r), .g(g), .b(b), .start(start), .busy(busy),
    .done(done), .line_err(line_err), .frame_err(frame_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .crc(crc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [23:0]   d;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          ignore_wr = 1'b0;
  logic        last_done = 1'b0;
  logic        prev_wr = 1'b0;
  logic [15:0] exp_crc = 16'h0000;
  wr_t         exp_q[$];
  wr_t         mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-16-CCITT, byte-oriented: pixel is r, g, b bytes in order.
  function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [23:0] d);
    logic [15:0] c;
    logic [7:0]  byt;
    c = c_in;
    for (int k = 2; k >= 0; k--) begin
      byt = d[k*8 +: 8];
      c = c ^ {byt, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] crc_expect();
`ifdef VGA_CAPTURE_CRC_EN
    return exp_crc;
`else
    return 16'h0000;
`endif
  endfunction

  // Write-port scoreboard and done counter.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 1'b0);
    end
    if (wr_en && !ignore_wr) begin
      wr_cnt++;
      check("wr_single_cycle", prev_wr, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected: observed addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", wr_addr, mon_e.a);
        check("wr_data", wr_data, mon_e.d);
      end
    end
    prev_wr = wr_en;
  end

  task automatic smp(input logic vs, input logic hs, input logic nb, input logic [23:0] px);
    vsync = vs; hsync = hs; n_blanc = nb; {r, g, b} = px; pix_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_done = done;
    pix_en = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic prologue();
    smp(1'b1, 1'b1, 1'b0, 24'h0); smp(1'b1, 1'b1, 1'b0, 24'h0);
    smp(1'b0, 1'b1, 1'b0, 24'h0); smp(1'b0, 1'b1, 1'b0, 24'h0);
    smp(1'b1, 1'b1, 1'b0, 24'h0); smp(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_crc = 16'hFFFF;
    check("start_busy", busy, 1'b1);
    check("start_line_err_clr", line_err, 1'b0);
    check("start_frame_err_clr", frame_err, 1'b0);
  endtask

  // mode 0: random pixels, 1: pixel = address, 2: all zero
  task automatic run_frame(input int nl, input int odd_l, input int odd_len, input int mode,
                           input bit merge, input int mid_l, input bit cap);
    int          w0, d0, len, n_exp;
    bit          exp_lerr;
    logic        end_done;
    logic [23:0] px;
    w0 = wr_cnt; d0 = done_cnt; n_exp = 0; exp_lerr = 1'b0; end_done = 1'b0;
    prologue();
    for (int l = 0; l < nl; l++) begin
      if (l == mid_l) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy", busy, 1'b1);
      end
      len = (l == odd_l) ? odd_len : H;
      if (len != H) exp_lerr = 1'b1;
      for (int j = 0; j < len; j++) begin
        px = (mode == 0) ? 24'($urandom) : (mode == 1) ? 24'(l * H + j) : 24'h0;
        if (cap && j < H) begin
          exp_q.push_back('{AW'(l * H + j), px});
          exp_crc = crc_fold(exp_crc, px);
          n_exp++;
        end
        smp(1'b1, 1'b1, 1'b1, px);
      end
      if (l == nl - 1 && merge) begin
        smp(1'b0, 1'b1, 1'b0, 24'h0);
        end_done = last_done;
      end else begin
        smp(1'b1, 1'b1, 1'b0, 24'h0);
        if (l == V - 1) end_done = last_done;
        smp(1'b1, 1'b0, 1'b0, 24'h0);
        smp(1'b1, 1'b1, 1'b0, 24'h0);
      end
    end
    if (nl < V && !merge) begin
      smp(1'b0, 1'b1, 1'b0, 24'h0);
      end_done = last_done;
    end
    smp(1'b0, 1'b1, 1'b0, 24'h0);
    smp(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (3) @(negedge clk);
    check("wr_count", wr_cnt - w0, cap ? n_exp : 0);
    check("exp_drained", exp_q.size(), 0);
    check("done_count", done_cnt - d0, cap ? 1 : 0);
    if (cap) check("done_timing", end_done, 1'b1);
    check("line_err", line_err, cap & exp_lerr);
    check("frame_err", frame_err, cap & (nl < V));
    check("busy_idle", busy, 1'b0);
    check("crc", crc, crc_expect());
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; n_blanc = 1'b0;
    {r, g, b} = 24'h0; start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) smp(1'b1, 1'b1, 1'b1, 24'($urandom));
    smp(1'b0, 1'b1, 1'b0, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_line_err", line_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_crc", crc, 0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    run_frame(V, -1, H, 1, 1'b0, -1, 1'b0);
    start_pulse(); run_frame(V, -1, H, 1, 1'b0, 5, 1'b1);
    start_pulse(); run_frame(V, 3, H - 1, 0, 1'b0, -1, 1'b1);
    start_pulse(); run_frame(V, 7, H + 3, 0, 1'b0, -1, 1'b1);
    start_pulse(); run_frame(5, -1, H, 0, 1'b0, -1, 1'b1);
    start_pulse(); run_frame(7, -1, H, 0, 1'b1, -1, 1'b1);
    start_pulse(); run_frame(V, -1, H, 2, 1'b0, -1, 1'b1);

    d0 = done_cnt;
    start_pulse();
    ignore_wr = 1'b1;
    prologue();
    for (int j = 0; j < H; j++) smp(1'b1, 1'b1, 1'b1, 24'($urandom));
    smp(1'b1, 1'b1, 1'b0, 24'h0);
    for (int j = 0; j < 3; j++) smp(1'b1, 1'b1, 1'b1, 24'($urandom));
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ignore_wr = 1'b0;
    exp_crc = 16'h0000;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_crc", crc, crc_expect());

    start_pulse(); run_frame(V, 2, H - 2, 0, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
